mux32_rr_arbiter: RTL and testbench
===================================

// Module: mux32_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 32-way datapath selector (mux_32, 5-bit
//  select) between up to 32 requesters. Drives the selector's select bus and a
//  one-hot grant vector. Bounds each owner's tenure with a hold limit, so no
//  requester can starve the others. Sits in front of the multdiv/ALU operand
//  selection path.
// PARAMETERS
//  N_REQ     32  number of requesters; power of 2, 2..32
//  ID_W      5   grant index width; equals log2(N_REQ)
//  MAX_HOLD  16  max consecutive cycles one owner may hold the grant; 0 = unlimited
// PORTS
//  clock        in   1      sole clock; all state updates on the rising edge
//  reset_n      in   1      synchronous, active-low reset
//  arb_en       in   1      1 = new grants allowed; 0 = freeze (hold owner or idle)
//  req          in   N_REQ  request vector; req[i] high while requester i wants the mux
//  grant_valid  out  1      registered; 1 = grant_id/grant_oh are valid
//  grant_id     out  ID_W   registered; drives the mux_32 select
//  grant_oh     out  N_REQ  registered; one-hot of grant_id, all-zero when !grant_valid
//  hold_cnt     out  5      registered; cycles the current owner has held, saturating
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state=IDLE, grant_valid=0, grant_id=0,
//    grant_oh=0, hold_cnt=0, rr_ptr=N_REQ-1, so index 0 has first priority.
//    Reset mid-tenure drops the grant on that same edge.
//  - Arbitration: search req from (rr_ptr+1) mod N_REQ upward with wrap-around.
//    The first set bit wins. On a grant, rr_ptr <= winner.
//  - Latency: a req rising at edge t is sampled at t; grant is visible after t.
//    Single-cycle registered arbitration; no combinational req->grant path.
//  - IDLE: if arb_en && |req -> GRANT, owner = winner, hold_cnt=0.
//    Otherwise stay in IDLE with outputs zero.
//  - GRANT, each edge, in priority order:
//    1) req[owner]=0 (release): pick the next winner from owner+1, excluding owner.
//       If arb_en && one exists -> GRANT to it, with no bubble cycle.
//       Otherwise -> IDLE.
//    2) MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 (expiry): same pick, with owner excluded.
//       If no other requester exists, the owner is re-granted and hold_cnt resets to 0.
//    3) Otherwise: keep owner, hold_cnt++ (saturate at 31).
//  - arb_en=0 in GRANT: owner keeps the grant until release. Expiry is ignored.
//    On release -> IDLE.
//  - Simultaneous release and expiry: release wins. Both resolve to the same pick.
//  - A requester dropping req while not granted has no effect. No request queue is kept.
//  - grant_id never changes while grant_valid stays 1 without a re-arb event.
//    Consumers sample the mux output whenever grant_valid=1.
//  - Width rules: indices are taken mod N_REQ. hold_cnt is 5 bits regardless of MAX_HOLD.
// STRUCTURE
//  - Shared package/header: N_REQ/ID_W defaults, state encoding
//    (ST_IDLE=1'b0, ST_GRANT=1'b1), and the MAX_HOLD default.
//  - One sub-module: rr_pick (combinational).
//    Inputs: req, start index, exclude mask.
//    Outputs: found and idx.
//    Implemented as rotate, then priority-encode, then un-rotate.
//  - Top: state register, owner/rr_ptr/hold_cnt registers, output registers.
// TESTING
//  1. Reset held with req=32'hFFFF_FFFF -> all outputs 0.
//     Release reset -> next edge grant_id=0, grant_oh=32'h1.
//  2. req=32'h0000_0014, owner 2 drops req at cycle 5.
//     -> grant_id=4 on the following edge with grant_valid continuously 1;
//     owner 4 drops -> grant_valid=0.
//  3. MAX_HOLD=16, req=32'h8000_0001 held constant.
//     -> grants alternate 0,31,0,... every 16 cycles; hold_cnt 0..15.
//  4. Wrap: owner 31 releases with req=32'h0000_0002 -> grant_id=1.
//     rr_ptr=1 afterwards, so index 2 is next in priority.
//  5. arb_en=0 while owner 7 is granted, req=32'h0000_0180, 40 cycles.
//     -> grant_id stays 7 past expiry, hold_cnt saturates at 31.
//     Owner 7 releases -> IDLE.
//  6. reset_n=0 for one edge mid-tenure (owner 9).
//     -> grant_valid=0 that edge; on recovery index 0 has priority again.

Source files
------------

// File: rtl/mux32_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux32_rr_arbiter_pkg
//   Shared definitions for the round-robin arbiter in front of the 32-way
//   operand selector: default geometry, FSM state encoding, hold-limit
//   defaults and the width/ceiling of the tenure counter.
// ----------------------------------------------------------------------------
package mux32_rr_arbiter_pkg;

    // Default geometry: 32 requesters, 5-bit select into mux_32.
    localparam int N_REQ_DEF    = 32;
    localparam int ID_W_DEF     = 5;

    // Default tenure limit in cycles; 0 disables the limit.
    localparam int MAX_HOLD_DEF = 16;

    // The tenure counter is always 5 bits, whatever MAX_HOLD is.
    localparam int              HOLD_W   = 5;
    localparam logic [HOLD_W-1:0] HOLD_SAT = 5'd31;

    // FSM state encoding, kept as plain constants for legacy tools.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage : mux32_rr_arbiter_pkg

// File: rtl/mux32_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin pick. Finds the first candidate at or above
//   'start', wrapping modulo N_REQ. Candidates are req bits not in 'excl'.
//   Structure: rotate so 'start' lands at bit 0, priority-encode the
//   lowest set bit, then add 'start' back to un-rotate.
//
// Ports
//   req    in  N_REQ  raw request vector
//   start  in  ID_W   index with highest priority this cycle
//   excl   in  N_REQ  mask of requesters that may not win
//   found  out 1      at least one candidate exists
//   idx    out ID_W   winning index (0 when !found)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 32,
    parameter int ID_W  = 5
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    input  logic [N_REQ-1:0] excl,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  rot_idx;

    assign cand = req & ~excl;

    // Rotate: rot[i] is the candidate i positions above 'start'. The index
    // sum is ID_W bits wide, so it wraps modulo N_REQ for free.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = cand[ID_W'(i) + start];
        end
    end

    // Priority-encode the lowest set bit. Scanning from the top down lets
    // the last hit, i.e. the lowest index, win.
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        found   = 1'b0;
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found   = 1'b1;
                rot_idx = ID_W'(i);
            end
        end
    end

    // Un-rotate back to an absolute requester index (mod N_REQ).
    assign idx = found ? (rot_idx + start) : '0;

endmodule : rr_pick

// File: rtl/mux32_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux32_rr_arbiter
//   Round-robin arbiter that shares one 32-way selector (mux_32, 5-bit
//   select) between up to N_REQ requesters. Each owner's tenure is bounded by
//   MAX_HOLD so nobody is starved. Arbitration is single-cycle and all
//   outputs are registered: there is no combinational req->grant path.
//
// Ports
//   clock        in   1      rising-edge clock
//   reset_n      in   1      synchronous, active-low reset
//   arb_en       in   1      1 = new grants allowed; 0 = freeze current state
//   req          in   N_REQ  request vector, req[i] high while i wants the mux
//   grant_valid  out  1      grant_id/grant_oh are valid
//   grant_id     out  ID_W   mux_32 select (0 when idle)
//   grant_oh     out  N_REQ  one-hot of grant_id, zero when idle
//   hold_cnt     out  5      cycles the current owner has held, saturating
// ----------------------------------------------------------------------------
module mux32_rr_arbiter
    import mux32_rr_arbiter_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              arb_en,
    input  logic [N_REQ-1:0]  req,
    output logic              grant_valid,
    output logic [ID_W-1:0]   grant_id,
    output logic [N_REQ-1:0]  grant_oh,
    output logic [HOLD_W-1:0] hold_cnt
);

    // Value of hold_cnt on the owner's last permitted cycle.
    localparam logic              HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST    =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    // ------------------------------------------------------------------
    // State. grant_id_q doubles as the owner register: it holds the owner
    // whenever state is GRANT, and is zero in IDLE.
    // ------------------------------------------------------------------
    logic [0:0]        state_q,       state_d;
    logic              grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]   grant_id_q,    grant_id_d;
    logic [N_REQ-1:0]  grant_oh_q,    grant_oh_d;
    logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic [ID_W-1:0]   rr_ptr_q,      rr_ptr_d;

    // ------------------------------------------------------------------
    // Picker. In GRANT, rr_ptr always equals the owner (it is loaded with
    // every winner), so "search from rr_ptr+1" also serves as "search from
    // owner+1". The owner is excluded so a release or an expiry can only
    // hand the mux to someone else.
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  pick_start;
    logic [N_REQ-1:0] pick_excl;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;

    assign pick_start = rr_ptr_q + ID_W'(1);

    always_comb begin
        pick_excl = '0;
        if (state_q == ST_GRANT) begin
            pick_excl[grant_id_q] = 1'b1;
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req),
        .start (pick_start),
        .excl  (pick_excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic owner_released;
    logic hold_expired;

    assign owner_released = ~req[grant_id_q];
    assign hold_expired   = HOLD_LIMITED && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        hold_cnt_d    = hold_cnt_q;
        rr_ptr_d      = rr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_en && pick_found) begin
                    state_d       = ST_GRANT;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_idx;
                    rr_ptr_d      = pick_idx;
                    hold_cnt_d    = '0;
                end
            end

            ST_GRANT: begin
                if (owner_released) begin
                    // Release beats expiry. Hand over with no bubble if
                    // possible; a frozen arbiter always falls back to IDLE.
                    if (arb_en && pick_found) begin
                        grant_id_d = pick_idx;
                        rr_ptr_d   = pick_idx;
                        hold_cnt_d = '0;
                    end else begin
                        state_d       = ST_IDLE;
                        grant_valid_d = 1'b0;
                        grant_id_d    = '0;
                        hold_cnt_d    = '0;
                    end
                end else if (arb_en && hold_expired) begin
                    // Tenure used up. With no competitor the owner keeps the
                    // mux but starts a fresh tenure.
                    if (pick_found) begin
                        grant_id_d = pick_idx;
                        rr_ptr_d   = pick_idx;
                    end
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d       = ST_IDLE;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
                hold_cnt_d    = '0;
            end
        endcase
    end

    // One-hot follows the next grant so it is registered alongside it.
    always_comb begin
        grant_oh_d = '0;
        if (grant_valid_d) begin
            grant_oh_d[grant_id_d] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            grant_oh_q    <= '0;
            hold_cnt_q    <= '0;
            rr_ptr_q      <= ID_W'(N_REQ - 1);
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            grant_oh_q    <= grant_oh_d;
            hold_cnt_q    <= hold_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign grant_oh    = grant_oh_q;
    assign hold_cnt    = hold_cnt_q;

endmodule : mux32_rr_arbiter

// File: tb/tb_mux32_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux32_rr_arbiter
//   Directed bench for mux32_rr_arbiter (N_REQ=32, MAX_HOLD=16). Inputs are
//   driven 1 time unit after a rising edge and outputs are sampled at the
//   same point, so each step() shows the result of exactly one edge.
// ----------------------------------------------------------------------------
module tb_mux32_rr_arbiter;

    logic        clock;
    logic        reset_n;
    logic        arb_en;
    logic [31:0] req;
    logic        grant_valid;
    logic [4:0]  grant_id;
    logic [31:0] grant_oh;
    logic [4:0]  hold_cnt;

    int n_tests;
    int n_fail;

    mux32_rr_arbiter #(
        .N_REQ    (32),
        .ID_W     (5),
        .MAX_HOLD (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .arb_en      (arb_en),
        .req         (req),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_oh    (grant_oh),
        .hold_cnt    (hold_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check the whole output set against an owner (valid=1) or idle.
    task automatic check_grant(input string tag, input int id, input int hc);
        check({tag, ".valid"}, {31'd0, grant_valid}, 32'd1);
        check({tag, ".id"},    {27'd0, grant_id},    32'(id));
        check({tag, ".oh"},    grant_oh,             32'd1 << id);
        check({tag, ".hold"},  {27'd0, hold_cnt},    32'(hc));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {31'd0, grant_valid}, 32'd0);
        check({tag, ".id"},    {27'd0, grant_id},    32'd0);
        check({tag, ".oh"},    grant_oh,             32'd0);
        check({tag, ".hold"},  {27'd0, hold_cnt},    32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        arb_en  = 1'b1;
        req     = 32'hFFFF_FFFF;

        // 1. Reset with every request high: outputs stay zero.
        step();
        step();
        check_idle("t1_reset");
        reset_n = 1'b1;
        step();
        check_grant("t1_first", 0, 0);

        // 2. Owner 2 releases after 5 cycles; 4 takes over with no bubble.
        do_reset();
        req = 32'h0000_0014;
        step();
        check_grant("t2_own2", 2, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_grant("t2_hold2", 2, k);
        end
        req = 32'h0000_0010;
        step();
        check_grant("t2_own4", 4, 0);
        req = 32'h0000_0000;
        step();
        check_idle("t2_idle");

        // 3. Two constant requesters alternate every 16 cycles.
        do_reset();
        req = 32'h8000_0001;
        step();
        check_grant("t3_own0", 0, 0);
        for (int k = 1; k <= 15; k++) begin
            step();
            check_grant("t3_hold0", 0, k);
        end
        step();
        check_grant("t3_own31", 31, 0);
        for (int k = 1; k <= 15; k++) begin
            step();
            check_grant("t3_hold31", 31, k);
        end
        step();
        check_grant("t3_back0", 0, 0);

        // 4. Wrap: owner 31 releases to requester 1; rr_ptr ends at 1.
        do_reset();
        req = 32'h8000_0000;
        step();
        check_grant("t4_own31", 31, 0);
        req = 32'h0000_0002;
        step();
        check_grant("t4_wrap1", 1, 0);
        req = 32'h0000_0000;
        step();
        check_idle("t4_idle");
        req = 32'h0000_0005;   // from rr_ptr+1=2: 2 beats 0
        step();
        check_grant("t4_ptr", 2, 0);

        // 5. Frozen arbiter: owner 7 keeps the mux past expiry.
        do_reset();
        req = 32'h0000_0080;
        step();
        check_grant("t5_own7", 7, 0);
        req    = 32'h0000_0180;
        arb_en = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            check({"t5_id"},   {27'd0, grant_id}, 32'd7);
            check({"t5_hold"}, {27'd0, hold_cnt}, (k > 31) ? 32'd31 : 32'(k));
        end
        req = 32'h0000_0100;
        step();
        check_idle("t5_rel_idle");
        arb_en = 1'b1;
        step();
        check_grant("t5_own8", 8, 0);

        // 6. Reset mid-tenure drops the grant; index 0 regains priority.
        do_reset();
        req = 32'h0000_0200;
        step();
        check_grant("t6_own9", 9, 0);
        step();
        req     = 32'h0000_0601;
        reset_n = 1'b0;
        step();
        check_idle("t6_reset");
        reset_n = 1'b1;
        step();
        check_grant("t6_recover", 0, 0);

        // 7. Expiry with no competitor re-grants the owner, fresh tenure.
        do_reset();
        req = 32'h0000_0008;
        step();
        check_grant("t7_own3", 3, 0);
        for (int k = 1; k <= 15; k++) begin
            step();
        end
        check_grant("t7_last", 3, 15);
        step();
        check_grant("t7_regrant", 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux32_rr_arbiter
